// File: rtl/proc_control_unit_if.sv
// Control-unit interface: instruction input side and datapath control outputs.
interface proc_control_unit_if;
   localparam int unsigned NREG  = 8;
   localparam int unsigned IMM_W = 9;

   logic             run;
   logic [15:0]      din;
   logic [3:0]       bus_sel;
   logic [NREG-1:0]  r_in;
   logic             a_in;
   logic             g_in;
   logic [2:0]       alu_op;
   logic [IMM_W-1:0] imm_out;
   logic [15:0]      ir;
   logic             busy;
   logic             done;
   logic             illegal;

   // Instruction source / datapath side
   modport master (
      output run, din,
      input  bus_sel, r_in, a_in, g_in, alu_op, imm_out, ir, busy, done, illegal
   );

   // Control unit side
   modport slave (
      input  run, din,
      output bus_sel, r_in, a_in, g_in, alu_op, imm_out, ir, busy, done, illegal
   );
endinterface

// File: rtl/proc_control_unit.sv
// Multicycle control FSM: latches one instruction and sequences it over T1..T3.
module proc_control_unit (
   input logic                  clk,
   input logic                  rst,
   proc_control_unit_if.slave   bus
);
   localparam int unsigned NREG  = 8;
   localparam int unsigned IMM_W = 9;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_RR  = 3'b101;
   localparam logic [2:0] OP_RL  = 3'b110;

   localparam logic [3:0] SEL_IMM  = 4'd8;
   localparam logic [3:0] SEL_G    = 4'd10;
   localparam logic [3:0] SEL_IDLE = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [15:0]       r_ir;

   logic [2:0]        w_op;
   logic [2:0]        w_rx;
   logic [2:0]        w_ry;
   logic [NREG-1:0]   w_rx_onehot;

   logic [3:0]        w_bus_sel;
   logic [NREG-1:0]   w_r_in;
   logic              w_a_in;
   logic              w_g_in;
   logic [2:0]        w_alu_op;
   logic              w_busy;
   logic              w_done;
   logic              w_illegal;

   assign w_op        = r_ir[15:13];
   assign w_rx        = r_ir[12:10];
   assign w_ry        = r_ir[8:6];
   assign w_rx_onehot = NREG'(1) << w_rx;

   // State register and instruction capture on the accepting IDLE edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ir    <= 16'h0000;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && bus.run) begin
            r_ir <= bus.din;
         end
      end
   end

   // Next-state and Moore control decode from state and IR
   always_comb begin
      w_next    = r_state;
      w_bus_sel = SEL_IDLE;
      w_r_in    = '0;
      w_a_in    = 1'b0;
      w_g_in    = 1'b0;
      w_alu_op  = 3'b000;
      w_busy    = (r_state != S_IDLE);
      w_done    = 1'b0;
      w_illegal = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.run) w_next = S_T1;
         end
         S_T1: begin
            unique case (w_op)
               OP_MV: begin
                  w_bus_sel = {1'b0, w_ry};
                  w_r_in    = w_rx_onehot;
                  w_done    = 1'b1;
                  w_next    = S_IDLE;
               end
               OP_MVI: begin
                  w_bus_sel = SEL_IMM;
                  w_r_in    = w_rx_onehot;
                  w_done    = 1'b1;
                  w_next    = S_IDLE;
               end
               OP_ADD, OP_SUB, OP_MUL: begin
                  w_bus_sel = {1'b0, w_rx};
                  w_a_in    = 1'b1;
                  w_next    = S_T2;
               end
               OP_RR, OP_RL: begin
                  w_bus_sel = {1'b0, w_ry};
                  w_alu_op  = (w_op == OP_RR) ? 3'b011 : 3'b100;
                  w_g_in    = 1'b1;
                  w_next    = S_T2;
               end
               default: begin
                  w_done    = 1'b1;
                  w_illegal = 1'b1;
                  w_next    = S_IDLE;
               end
            endcase
         end
         S_T2: begin
            if (w_op == OP_RR || w_op == OP_RL) begin
               w_bus_sel = SEL_G;
               w_r_in    = w_rx_onehot;
               w_done    = 1'b1;
               w_next    = S_IDLE;
            end else if (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_MUL) begin
               // ADD/SUB/MUL opcodes map onto ALU codes 000/001/010
               w_bus_sel = {1'b0, w_ry};
               w_alu_op  = 3'(w_op - OP_ADD);
               w_g_in    = 1'b1;
               w_next    = S_T3;
            end else begin
               w_next    = S_IDLE;
            end
         end
         S_T3: begin
            w_bus_sel = SEL_G;
            w_r_in    = w_rx_onehot;
            w_done    = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.bus_sel = w_bus_sel;
   assign bus.r_in    = w_r_in;
   assign bus.a_in    = w_a_in;
   assign bus.g_in    = w_g_in;
   assign bus.alu_op  = w_alu_op;
   assign bus.imm_out = r_ir[IMM_W-1:0];
   assign bus.ir      = r_ir;
   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
   assign bus.illegal = w_illegal;
endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: directed test-plan scenarios plus random instructions.
module tb_proc_control_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   proc_control_unit_if bus ();

   proc_control_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Observed outputs packed: busy,bus_sel,r_in,a_in,g_in,alu_op,done,illegal,imm_out,ir
   function automatic logic [44:0] obs();
      return {bus.busy, bus.bus_sel, bus.r_in, bus.a_in, bus.g_in, bus.alu_op,
              bus.done, bus.illegal, bus.imm_out, bus.ir};
   endfunction

   function automatic logic [44:0] mk(input logic b, input logic [3:0] bs,
                                      input logic [7:0] rin, input logic a,
                                      input logic g, input logic [2:0] alu,
                                      input logic d, input logic ill,
                                      input logic [15:0] ins);
      return {b, bs, rin, a, g, alu, d, ill, ins[8:0], ins};
   endfunction

   // Number of steps an instruction takes from acceptance to done
   function automatic int latency(input logic [15:0] ins);
      case (ins[15:13])
         3'd2, 3'd3, 3'd4: return 3;
         3'd5, 3'd6:       return 2;
         default:          return 1;
      endcase
   endfunction

   // Expected outputs in step k (1..latency) of instruction ins; k=0 is IDLE holding ins
   function automatic logic [44:0] exp_vec(input logic [15:0] ins, input int k);
      logic [2:0] op, rx, ry, alu;
      logic [3:0] bx, by;
      logic [7:0] oh;
      op = ins[15:13]; rx = ins[12:10]; ry = ins[8:6];
      bx = {1'b0, rx}; by = {1'b0, ry};
      oh = 8'd0; oh[rx] = 1'b1;
      if (k == 0) return mk(0, 4'd15, 8'd0, 0, 0, 3'd0, 0, 0, ins);
      case (op)
         3'd0: return mk(1, by, oh, 0, 0, 3'd0, 1, 0, ins);
         3'd1: return mk(1, 4'd8, oh, 0, 0, 3'd0, 1, 0, ins);
         3'd2, 3'd3, 3'd4: begin
            alu = (op == 3'd2) ? 3'd0 : (op == 3'd3) ? 3'd1 : 3'd2;
            if (k == 1) return mk(1, bx, 8'd0, 1, 0, 3'd0, 0, 0, ins);
            if (k == 2) return mk(1, by, 8'd0, 0, 1, alu, 0, 0, ins);
            return mk(1, 4'd10, oh, 0, 0, 3'd0, 1, 0, ins);
         end
         3'd5, 3'd6: begin
            alu = (op == 3'd5) ? 3'd3 : 3'd4;
            if (k == 1) return mk(1, by, 8'd0, 0, 1, alu, 0, 0, ins);
            return mk(1, 4'd10, oh, 0, 0, 3'd0, 1, 0, ins);
         end
         default: return mk(1, 4'd15, 8'd0, 0, 0, 3'd0, 1, 1, ins);
      endcase
   endfunction

   // Issue one instruction from IDLE and check every step plus the following IDLE cycle
   task automatic run_instr(input logic [15:0] ins, input string tag);
      int lat;
      lat = latency(ins);
      @(negedge clk);
      bus.din = ins;
      bus.run = 1'b1;
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         n_cmp++;
         if (obs() !== exp_vec(ins, k)) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", tag, k, obs(), exp_vec(ins, k));
         end
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (obs() !== exp_vec(ins, 0)) begin
         n_err++;
         $display("FAIL %s idle-after: got %h want %h", tag, obs(), exp_vec(ins, 0));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.run = 1'b0;
      bus.din = 16'h0000;
      #1;
      n_cmp++;
      if (obs() !== mk(0, 4'd15, 8'd0, 0, 0, 3'd0, 0, 0, 16'h0)) begin
         n_err++;
         $display("FAIL reset_state: got %h", obs());
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.bus_sel !== 4'd15) begin
         n_err++;
         $display("FAIL reset_release: busy=%b bus_sel=%0d want 0/15", bus.busy, bus.bus_sel);
      end
   endtask

   task automatic test_mvi();
      @(negedge clk);
      bus.din = 16'h29FB;
      bus.run = 1'b1;
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      n_cmp++;
      if (bus.bus_sel !== 4'd8 || bus.imm_out !== 9'h1FB || bus.r_in !== 8'b0000_0100 ||
          bus.done !== 1'b1 || bus.illegal !== 1'b0 || bus.a_in !== 1'b0 || bus.g_in !== 1'b0) begin
         n_err++;
         $display("FAIL mvi_t1: bus_sel=%0d imm=%h r_in=%b done=%b want 8/1fb/00000100/1",
                  bus.bus_sel, bus.imm_out, bus.r_in, bus.done);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.r_in !== 8'd0) begin
         n_err++;
         $display("FAIL mvi_idle: busy=%b done=%b r_in=%b want 0/0/0", bus.busy, bus.done, bus.r_in);
      end
   endtask

   task automatic test_add();
      run_instr(16'h4500, "add_r1_r4");
   endtask

   task automatic test_rl();
      run_instr(16'hDC00, "rl_r7_r0");
   endtask

   task automatic test_illegal();
      run_instr(16'hE000, "illegal");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.din = 16'h0140;
      bus.run = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== exp_vec(16'h0140, 1)) begin
         n_err++;
         $display("FAIL b2b_mv_t1: got %h want %h", obs(), exp_vec(16'h0140, 1));
      end
      @(negedge clk);
      bus.din = 16'h7980;
      #1;
      n_cmp++;
      if (obs() !== exp_vec(16'h0140, 1)) begin
         n_err++;
         $display("FAIL b2b_din_ignored: got %h want %h", obs(), exp_vec(16'h0140, 1));
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== exp_vec(16'h0140, 0)) begin
         n_err++;
         $display("FAIL b2b_gap_idle: got %h want %h", obs(), exp_vec(16'h0140, 0));
      end
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) bus.run = 1'b0;
         n_cmp++;
         if (obs() !== exp_vec(16'h7980, k)) begin
            n_err++;
            $display("FAIL b2b_sub_step%0d: got %h want %h", k, obs(), exp_vec(16'h7980, k));
         end
         if (k < 3) begin
            n_cmp++;
            if (bus.bus_sel !== 4'd6) begin
               n_err++;
               $display("FAIL b2b_sub_sel%0d: got %0d want 6", k, bus.bus_sel);
            end
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== exp_vec(16'h7980, 0)) begin
         n_err++;
         $display("FAIL b2b_sub_idle: got %h want %h", obs(), exp_vec(16'h7980, 0));
      end
   endtask

   task automatic test_reset_mid_add();
      @(negedge clk);
      bus.din = 16'h4500;
      bus.run = 1'b1;
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== exp_vec(16'h4500, 2)) begin
         n_err++;
         $display("FAIL rst_pre_t2: got %h want %h", obs(), exp_vec(16'h4500, 2));
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== mk(0, 4'd15, 8'd0, 0, 0, 3'd0, 0, 0, 16'h0)) begin
         n_err++;
         $display("FAIL rst_async_idle: got %h", obs());
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.bus_sel !== 4'd15 || bus.r_in !== 8'd0) begin
         n_err++;
         $display("FAIL rst_after_release: busy=%b bus_sel=%0d r_in=%b", bus.busy, bus.bus_sel, bus.r_in);
      end
      run_instr(16'h2410, "post_reset_mvi");
   endtask

   task automatic test_random();
      logic [15:0] ins;
      int gap;
      for (int i = 0; i < 60; i++) begin
         ins = 16'($urandom);
         run_instr(ins, $sformatf("rand%0d_%h", i, ins));
         gap = int'($urandom_range(0, 2));
         for (int j = 0; j < gap; j++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== exp_vec(ins, 0)) begin
               n_err++;
               $display("FAIL rand%0d_gap: got %h want %h", i, obs(), exp_vec(ins, 0));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mvi();
      test_add();
      test_rl();
      test_illegal();
      test_back_to_back();
      test_reset_mid_add();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
